// File: rtl/nn_fixed_pkg.sv
// Shared Q4.4 fixed-point constants, saturation helper and neuron FSM states.
// The activation stage imports the same format constants.
package nn_fixed_pkg;

  localparam int DATA_W = 8;
  localparam int FRAC_W = 4;
  localparam int Q_MAX  = 127;
  localparam int Q_MIN  = -128;

  typedef enum logic [1:0] {ACCUM, FINISH, OUTPUT} state_e;

  // Clamp an already-rescaled value into the signed DATA_W range.
  function automatic logic [DATA_W-1:0] sat_q44(input logic signed [31:0] v);
    logic [DATA_W-1:0] r;
    if (v > Q_MAX) begin
      r = Q_MAX[DATA_W-1:0];
    end else if (v < Q_MIN) begin
      r = Q_MIN[DATA_W-1:0];
    end else begin
      r = v[DATA_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/neuron_weight_mem.sv
// Per-input weight register file: synchronous write, combinational read.
// Cleared to zero by the asynchronous active-low reset.
module neuron_weight_mem #(
  parameter int N_INPUTS = 4,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = $clog2(N_INPUTS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [N_INPUTS-1:0][DATA_W-1:0] words;

  generate
    for (genvar gi = 0; gi < N_INPUTS; gi++) begin : g_word
      logic [DATA_W-1:0] word_reg;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          word_reg <= '0;
        end else if (we && (wr_addr == ADDR_W'(gi))) begin
          word_reg <= wr_data;
        end
      end

      assign words[gi] = word_reg;
    end
  endgenerate

  assign rd_data = words[rd_addr];

endmodule

// File: rtl/neuron_mac_accumulator.sv
// Serial MAC neuron: accumulates x*w over N_INPUTS beats, adds bias, rescales
// to Q4.4 with floor, saturates once and hands z_value downstream.
module neuron_mac_accumulator
  import nn_fixed_pkg::*;
#(
  parameter int N_INPUTS = 4,
  parameter int DATA_W   = 8,
  parameter int FRAC_W   = 4,
  parameter int ACC_W    = 20,
  parameter int IDX_W    = $clog2(N_INPUTS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [DATA_W-1:0] x_data,
  input  logic              x_valid,
  output logic              x_ready,
  input  logic              w_we,
  input  logic [IDX_W-1:0]  w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              b_we,
  input  logic [DATA_W-1:0] b_data,
  output logic [DATA_W-1:0] z_value,
  output logic              z_valid,
  input  logic              z_ready
);

  state_e                   state_reg, state_next;
  logic [IDX_W-1:0]         idx_reg, idx_next;
  logic signed [ACC_W-1:0]  acc_reg, acc_next;
  logic [DATA_W-1:0]        bias_reg;
  logic [DATA_W-1:0]        z_value_reg, z_value_next;
  logic                     z_valid_reg, z_valid_next;

  logic [DATA_W-1:0]         w_rd;
  logic signed [2*DATA_W-1:0] x_ext, w_ext, product;
  logic signed [ACC_W-1:0]   product_ext, bias_ext, biased, scaled;
  logic                      mac_fire, z_fire;

  neuron_weight_mem #(
    .N_INPUTS(N_INPUTS),
    .DATA_W  (DATA_W),
    .ADDR_W  (IDX_W)
  ) u_weight_mem (
    .clk    (clk),
    .rst    (rst),
    .we     (w_we),
    .wr_addr(w_addr),
    .wr_data(w_data),
    .rd_addr(idx_reg),
    .rd_data(w_rd)
  );

  // Operands widened first so the Q8.8 product is formed at full width.
  assign x_ext       = {{DATA_W{x_data[DATA_W-1]}}, x_data};
  assign w_ext       = {{DATA_W{w_rd[DATA_W-1]}}, w_rd};
  assign product     = x_ext * w_ext;
  assign product_ext = {{(ACC_W-2*DATA_W){product[2*DATA_W-1]}}, product};
  assign bias_ext    = {{(ACC_W-DATA_W){bias_reg[DATA_W-1]}}, bias_reg} <<< FRAC_W;
  assign biased      = acc_reg + bias_ext;
  assign scaled      = biased >>> FRAC_W;

  assign x_ready  = (state_reg == ACCUM);
  assign mac_fire = x_valid && x_ready;
  assign z_fire   = z_valid_reg && z_ready;

  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    acc_next     = acc_reg;
    z_value_next = z_value_reg;
    z_valid_next = z_valid_reg;
    // clear overrides any handshake in the same cycle.
    if (clear) begin
      state_next   = ACCUM;
      idx_next     = '0;
      acc_next     = '0;
      z_valid_next = 1'b0;
    end else begin
      case (state_reg)
        ACCUM: begin
          if (mac_fire) begin
            acc_next = acc_reg + product_ext;
            if (idx_reg == IDX_W'(N_INPUTS - 1)) begin
              idx_next   = '0;
              state_next = FINISH;
            end else begin
              idx_next = idx_reg + IDX_W'(1);
            end
          end
        end
        FINISH: begin
          z_value_next = sat_q44(32'(scaled));
          z_valid_next = 1'b1;
          state_next   = OUTPUT;
        end
        OUTPUT: begin
          if (z_fire) begin
            z_valid_next = 1'b0;
            acc_next     = '0;
            state_next   = ACCUM;
          end
        end
        default: state_next = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= ACCUM;
      idx_reg     <= '0;
      acc_reg     <= '0;
      bias_reg    <= '0;
      z_value_reg <= '0;
      z_valid_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      acc_reg     <= acc_next;
      z_value_reg <= z_value_next;
      z_valid_reg <= z_valid_next;
      if (b_we) begin
        bias_reg <= b_data;
      end
    end
  end

  assign z_value = z_value_reg;
  assign z_valid = z_valid_reg;

endmodule
